uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command-frame controller between the UART byte receiver and the car motion logic.
//  - Consumes the receiver's byte strobe (rx_done) and data (rx_data).
//  - Assembles 4-byte frames HEADER,CMD,PARAM,CHK and validates them.
//  - Presents each accepted command as a one-cycle strobe with held code/param.
//  - Supervises link health: an inter-byte timeout aborts partial frames; a link
//    watchdog drops link_ok so the motion logic can stop the car.
// PARAMETERS
//  HEADER       8'hAA        frame start byte
//  BYTE_TO_CYC  250_000      max clk cycles between bytes inside a frame (2 ms @125 MHz)
//  LINK_TO_CYC  62_500_000   max clk cycles between accepted frames (500 ms @125 MHz)
// PORTS
//  clk        in   1  system clock, 125 MHz
//  rst        in   1  asynchronous reset, active-high
//  rx_data    in   8  received byte; valid only while rx_done=1
//  rx_done    in   1  one-cycle strobe, new byte on rx_data
//  cmd_valid  out  1  one-cycle strobe, accepted frame
//  cmd_code   out  8  CMD byte of the last accepted frame, held
//  cmd_param  out  8  PARAM byte of the last accepted frame, held
//  frame_err  out  1  one-cycle strobe: checksum mismatch or inter-byte timeout
//  link_ok    out  1  high while accepted frames arrive within LINK_TO_CYC
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0. cmd_valid=0, cmd_code=0, cmd_param=0, frame_err=0,
//   link_ok=0. Reset mid-frame discards the partial frame.
//  FSM, advancing only on rx_done=1:
//   IDLE : byte==HEADER -> CMD. Any other byte is ignored silently (no frame_err).
//   CMD  : latch byte into cmd_tmp -> PARAM. HEADER here is data; no resync.
//   PARAM: latch byte into par_tmp -> CHK.
//   CHK  : byte==(cmd_tmp^par_tmp) -> accept, else frame_err. Both cases -> IDLE.
//  Accept:
//   - cmd_code<=cmd_tmp, cmd_param<=par_tmp, cmd_valid=1, all on the clk edge after the
//     CHK rx_done cycle. Latency = 1 cycle.
//   - cmd_code/cmd_param change only on accept.
//  Byte timer (32-bit):
//   - Cleared on every rx_done and whenever state is IDLE.
//   - Otherwise increments each cycle.
//   - Timeout fires when it reaches BYTE_TO_CYC-1 with rx_done=0: frame_err=1 next cycle,
//     state->IDLE, timer cleared.
//   - rx_done in the same cycle as expiry: the byte wins, no timeout.
//  Link watchdog (32-bit):
//   - Cleared on accept; otherwise increments.
//   - Saturates at LINK_TO_CYC-1 (no wrap).
//   - link_ok is set to 1 on accept.
//   - link_ok is cleared to 0 on the cycle after the counter reaches LINK_TO_CYC-1.
//   - Accept in that same cycle keeps link_ok=1.
//  cmd_valid and frame_err are registered and never high in the same cycle.
//  rx_data is ignored while rx_done=0.
// TESTING
//  - Frame AA 01 64 65, bytes 10 cycles apart -> cmd_valid 1 cycle after the 4th rx_done;
//    cmd_code=01, cmd_param=64, link_ok=1.
//  - Frame AA 02 10 FF -> frame_err pulse, no cmd_valid, cmd_code/param keep the prior
//    values (01/64).
//  - Bytes 00 55 AA 03 05 06 -> leading 00/55 ignored; accept with code=03, param=05.
//  - AA 01 then silence, BYTE_TO_CYC overridden to 100 -> frame_err exactly 100 cycles
//    after the 2nd rx_done. Then AA 01 64 65 -> accepted.
//  - Valid frame, then no traffic, LINK_TO_CYC overridden to 1000 -> link_ok falls
//    1000 cycles after the accept. Next valid frame -> link_ok=1.
//  - rst pulsed after AA 01 -> all outputs 0. Following 64 65 is ignored; only a
//    fresh full frame is accepted.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: assembles HEADER,CMD,PARAM,CHK frames from UART bytes,
// strobes accepted commands and supervises inter-byte and inter-frame link timing.
module uart_cmd_ctrl #(
  parameter logic [7:0]  HEADER      = 8'hAA,
  parameter int unsigned BYTE_TO_CYC = 250_000,
  parameter int unsigned LINK_TO_CYC = 62_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_param,
  output logic       frame_err,
  output logic       link_ok
);

  localparam logic [31:0] BYTE_LAST = 32'(BYTE_TO_CYC - 1);
  localparam logic [31:0] LINK_LAST = 32'(LINK_TO_CYC - 1);

  typedef enum logic [1:0] {IDLE, CMD, PARAM, CHK} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cmd_tmp;
  logic [7:0]  par_tmp;
  logic [31:0] byte_tmr;
  logic [31:0] link_tmr;
  logic        timeout;
  logic        accept;
  logic        valid_nxt;
  logic        err_nxt;

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout = (state != IDLE) && !rx_done && (byte_tmr == BYTE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (rx_done) begin
      case (state)
        IDLE:    if (rx_data == HEADER) state_nxt = CMD;
        CMD:     state_nxt = PARAM;
        PARAM:   state_nxt = CHK;
        CHK:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    accept    = 1'b0;
    valid_nxt = 1'b0;
    err_nxt   = timeout;
    if (state == CHK && rx_done) begin
      if (rx_data == (cmd_tmp ^ par_tmp)) begin
        accept    = 1'b1;
        valid_nxt = 1'b1;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_tmp   <= '0;
      par_tmp   <= '0;
      cmd_code  <= '0;
      cmd_param <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_done && state == CMD)   cmd_tmp <= rx_data;
      if (rx_done && state == PARAM) par_tmp <= rx_data;
      if (accept) begin
        cmd_code  <= cmd_tmp;
        cmd_param <= par_tmp;
      end
      cmd_valid <= valid_nxt;
      frame_err <= err_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_tmr <= '0;
    end else if (rx_done || state == IDLE || timeout) begin
      byte_tmr <= '0;
    end else begin
      byte_tmr <= byte_tmr + 32'd1;
    end
  end

  // Watchdog saturates so link_ok stays low indefinitely once the link is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_tmr <= '0;
      link_ok  <= 1'b0;
    end else begin
      if (accept)                      link_tmr <= '0;
      else if (link_tmr != LINK_LAST)  link_tmr <= link_tmr + 32'd1;

      if (accept)                      link_ok <= 1'b1;
      else if (link_tmr == LINK_LAST)  link_ok <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized bench for uart_cmd_ctrl against an event-timing reference model
// (byte queue plus edge timestamps), with directed scenarios up front.
module tb_uart_cmd_ctrl;

  localparam int BYTE_TO = 100;
  localparam int LINK_TO = 1000;
  localparam logic [7:0] HDR = 8'hAA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_param;
  logic       frame_err;
  logic       link_ok;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  int   cyc = 0;
  int   last_byte = 0;
  int   last_acc = 0;
  bit   acc_seen = 0;
  logic       e_valid = 0, e_err = 0, e_link = 0;
  logic [7:0] e_code = 0, e_param = 0;

  uart_cmd_ctrl #(
    .HEADER(HDR), .BYTE_TO_CYC(BYTE_TO), .LINK_TO_CYC(LINK_TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_param(cmd_param),
    .frame_err(frame_err), .link_ok(link_ok)
  );

  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: frame = queue of bytes since a header, timing from edge stamps.
  task automatic model(input logic r, input logic d, input logic [7:0] b);
    cyc++;
    if (r) begin
      q.delete();
      e_valid = 0; e_err = 0; e_link = 0; e_code = 0; e_param = 0;
      acc_seen = 0;
      return;
    end
    e_valid = 0;
    e_err   = 0;
    if (d) begin
      last_byte = cyc;
      if (q.size() == 0) begin
        if (b == HDR) q.push_back(b);
      end else begin
        q.push_back(b);
        if (q.size() == 4) begin
          if (b == (q[1] ^ q[2])) begin
            e_valid = 1; e_code = q[1]; e_param = q[2];
            last_acc = cyc; acc_seen = 1;
          end else begin
            e_err = 1;
          end
          q.delete();
        end
      end
    end else if (q.size() > 0 && (cyc - last_byte) >= BYTE_TO) begin
      e_err = 1;
      q.delete();
    end
    e_link = acc_seen && ((cyc - last_acc) < LINK_TO);
  endtask

  task automatic step(input logic r, input logic d, input logic [7:0] b);
    rst = r; rx_done = d; rx_data = b;
    @(posedge clk);
    model(r, d, b);
    #1;
    check("cmd_valid", 32'(cmd_valid), 32'(e_valid));
    check("frame_err", 32'(frame_err), 32'(e_err));
    check("cmd_code",  32'(cmd_code),  32'(e_code));
    check("cmd_param", 32'(cmd_param), 32'(e_param));
    check("link_ok",   32'(link_ok),   32'(e_link));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b0, 1'b1, b);
    idle(gap);
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] p, input logic [7:0] k, input int gap);
    send(HDR, gap); send(c, gap); send(p, gap); send(k, gap);
  endtask

  initial begin
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("rst_link", 32'(link_ok), 32'd0);
    idle(3);

    // Basic accept with 10-cycle spacing.
    send(HDR, 9); send(8'h01, 9); send(8'h64, 9); send(8'h65, 0);
    check("t1_valid", 32'(cmd_valid), 32'd1);
    check("t1_code",  32'(cmd_code),  32'h01);
    check("t1_param", 32'(cmd_param), 32'h64);
    check("t1_link",  32'(link_ok),   32'd1);
    idle(10);

    // Bad checksum keeps previous command.
    send(HDR, 3); send(8'h02, 3); send(8'h10, 3); send(8'hFF, 0);
    check("t2_err",   32'(frame_err), 32'd1);
    check("t2_valid", 32'(cmd_valid), 32'd0);
    check("t2_code",  32'(cmd_code),  32'h01);
    idle(5);

    // Leading junk ignored.
    send(8'h00, 2); send(8'h55, 2);
    check("t3_noerr", 32'(frame_err), 32'd0);
    frame(8'h03, 8'h05, 8'h06, 2);
    check("t3_code",  32'(cmd_code),  32'h03);
    check("t3_param", 32'(cmd_param), 32'h05);

    // Inter-byte timeout exactly BYTE_TO edges after the last byte.
    send(HDR, 0); send(8'h01, 0);
    idle(BYTE_TO - 1);
    check("t4_early", 32'(frame_err), 32'd0);
    idle(1);
    check("t4_to", 32'(frame_err), 32'd1);
    frame(8'h01, 8'h64, 8'h65, 1);
    check("t4_code", 32'(cmd_code), 32'h01);

    // Byte arriving on the expiry cycle wins.
    send(HDR, 0); send(8'h07, BYTE_TO - 1); send(8'h08, 0);
    check("t5_nofire", 32'(frame_err), 32'd0);
    send(8'h0F, 0);
    check("t5_valid", 32'(cmd_valid), 32'd1);

    // Link watchdog falls LINK_TO edges after an accept.
    idle(LINK_TO - 1);
    check("t6_still", 32'(link_ok), 32'd1);
    idle(1);
    check("t6_drop", 32'(link_ok), 32'd0);
    frame(8'h09, 8'h0A, 8'h03, 1);
    check("t6_back", 32'(link_ok), 32'd1);

    // Reset mid-frame discards the partial frame.
    send(HDR, 1); send(8'h01, 1);
    step(1'b1, 1'b0, 8'h00);
    check("t7_code", 32'(cmd_code), 32'd0);
    check("t7_link", 32'(link_ok),  32'd0);
    idle(2);
    send(8'h64, 1); send(8'h65, 1);
    check("t7_code2", 32'(cmd_code), 32'd0);
    frame(8'h01, 8'h64, 8'h65, 1);
    check("t7_code3", 32'(cmd_code), 32'h01);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int kind;
      int gap;
      logic [7:0] c, p, k;
      kind = int'($urandom_range(0, 19));
      gap  = int'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) gap = int'($urandom_range(95, 104));
      c = ($urandom_range(0, 7) == 0) ? HDR : 8'($urandom);
      p = 8'($urandom);
      k = c ^ p;
      if (kind < 10) begin
        frame(c, p, k, gap);
      end else if (kind < 13) begin
        frame(c, p, k ^ 8'(1 << $urandom_range(0, 7)), gap);
      end else if (kind < 16) begin
        send(8'($urandom), gap);
      end else if (kind < 18) begin
        send(HDR, gap);
        send(c, int'($urandom_range(90, 110)));
      end else if (kind == 18) begin
        idle(int'($urandom_range(950, 1050)));
      end else begin
        if ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, 8'h00);
        else idle(gap);
      end
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
